// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl : run/pause/idle stopwatch FSM with prescaler, elapsed count,
// lap capture and saturate-or-wrap limit (rollover via STOPWATCH_ROLLOVER_EN).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100,
  parameter int CNT_W     = 16,
  parameter int MAX_COUNT = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  output logic [1:0]       state,
  output logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic [CNT_W-1:0] lap_value,
  output logic             lap_valid,
  output logic             at_max
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   COUNT_LAST = CNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic               enable_q;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               tick_q, tick_d;
  logic [CNT_W-1:0]   lap_value_q, lap_value_d;
  logic               lap_valid_q, lap_valid_d;
  logic               inc_event;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      presc_q     <= '0;
      count_q     <= '0;
      tick_q      <= 1'b0;
      lap_value_q <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= (state_d == RUNNING);
      presc_q     <= presc_d;
      count_q     <= count_d;
      tick_q      <= tick_d;
      lap_value_q <= lap_value_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign inc_event = (state_q == RUNNING) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    count_d     = count_q;
    tick_d      = 1'b0;
    lap_value_d = lap_value_q;
    lap_valid_d = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      presc_d     = '0;
      count_d     = '0;
      lap_value_d = '0;
    end else begin
      // Capture uses the register value, i.e. pre-increment on a shared edge.
      if (lap && (state_q == RUNNING || state_q == PAUSED)) begin
        lap_value_d = count_q;
        lap_valid_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start && !stop) state_d = RUNNING;
        end
        RUNNING: begin
          if (inc_event) begin
            presc_d = '0;
            if (count_q == COUNT_LAST) begin
`ifdef STOPWATCH_ROLLOVER_EN
              count_d = '0;
              tick_d  = 1'b1;
`else
              state_d = PAUSED;
`endif
            end else begin
              count_d = count_q + CNT_W'(1);
              tick_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
          if (stop) state_d = PAUSED;
        end
        PAUSED: begin
          if (start && !stop) state_d = RUNNING;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign enable    = enable_q;
  assign count     = count_q;
  assign tick      = tick_q;
  assign lap_value = lap_value_q;
  assign lap_valid = lap_valid_q;
  assign at_max    = (count_q == COUNT_LAST);

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl : two stopwatch instances (TICK_DIV 4 and 1) driven by
// shared directed + random pulses, checked against a behavioural model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;

  logic [1:0] st_a, st_b;
  logic       en_a, en_b, tk_a, tk_b, lv_a, lv_b, am_a, am_b;
  logic [7:0] cnt_a, lval_a;
  logic [3:0] cnt_b, lval_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(4), .CNT_W(8), .MAX_COUNT(9)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .state(st_a), .enable(en_a), .count(cnt_a), .tick(tk_a),
    .lap_value(lval_a), .lap_valid(lv_a), .at_max(am_a)
  );

  stopwatch_ctrl #(.TICK_DIV(1), .CNT_W(4), .MAX_COUNT(9)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .state(st_b), .enable(en_b), .count(cnt_b), .tick(tk_b),
    .lap_value(lval_b), .lap_valid(lv_b), .at_max(am_b)
  );

  // Reference model: mode 0 idle, 1 running, 2 paused; phase = cycles run
  // since the last increment.
  int div [2] = '{4, 1};
  int maxc = 9;
  int m_mode [2], m_phase [2], m_cnt [2], m_tick [2], m_lapv [2], m_lvld [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mode[i] = 0; m_phase[i] = 0; m_cnt[i] = 0;
        m_tick[i] = 0; m_lapv[i] = 0; m_lvld[i] = 0;
      end else begin
        m_tick[i] = 0;
        m_lvld[i] = 0;
        if (clear) begin
          m_mode[i] = 0; m_phase[i] = 0; m_cnt[i] = 0; m_lapv[i] = 0;
        end else begin
          if (lap && m_mode[i] != 0) begin
            m_lapv[i] = m_cnt[i];
            m_lvld[i] = 1;
          end
          if (m_mode[i] == 1) begin
            m_phase[i] = m_phase[i] + 1;
            if (m_phase[i] == div[i]) begin
              m_phase[i] = 0;
              if (m_cnt[i] < maxc) begin
                m_cnt[i] = m_cnt[i] + 1;
                m_tick[i] = 1;
              end else begin
`ifdef STOPWATCH_ROLLOVER_EN
                m_cnt[i] = 0;
                m_tick[i] = 1;
`else
                m_mode[i] = 2;
`endif
              end
            end
            if (stop) m_mode[i] = 2;
          end else if (start && !stop) begin
            m_mode[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a.state", 32'(st_a), m_mode[0]);
    check("a.enable", 32'(en_a), 32'(m_mode[0] == 1));
    check("a.count", 32'(cnt_a), m_cnt[0]);
    check("a.tick", 32'(tk_a), m_tick[0]);
    check("a.lap_value", 32'(lval_a), m_lapv[0]);
    check("a.lap_valid", 32'(lv_a), m_lvld[0]);
    check("a.at_max", 32'(am_a), 32'(m_cnt[0] == maxc));
    check("b.state", 32'(st_b), m_mode[1]);
    check("b.enable", 32'(en_b), 32'(m_mode[1] == 1));
    check("b.count", 32'(cnt_b), m_cnt[1]);
    check("b.tick", 32'(tk_b), m_tick[1]);
    check("b.lap_value", 32'(lval_b), m_lapv[1]);
    check("b.lap_valid", 32'(lv_b), m_lvld[1]);
    check("b.at_max", 32'(am_b), 32'(m_cnt[1] == maxc));
  endtask

  task automatic cyc(input logic s, input logic p, input logic c,
                     input logic l, input logic r);
    start = s; stop = p; clear = c; lap = l; reset = r;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    start = 0; stop = 0; clear = 0; lap = 0; reset = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset and basic run
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);            // lap in IDLE ignored
    cyc(1, 0, 0, 0, 0);
    idle_cycles(12);
    // Pause mid-tick, hold, resume
    cyc(0, 1, 0, 0, 0);
    idle_cycles(10);
    cyc(1, 0, 0, 0, 0);
    idle_cycles(3);
    cyc(0, 0, 0, 1, 0);            // lap while running
    idle_cycles(2);
    // start+stop together while running, then in IDLE
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);            // clear wins over start
    cyc(1, 1, 0, 0, 0);
    // Run into the limit on both instances
    cyc(1, 0, 0, 0, 0);
    idle_cycles(45);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);            // resume at MAX_COUNT
    idle_cycles(8);
    // Reset mid-run, then a fresh start
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle_cycles(6);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    idle_cycles(5);
    // Clear together with lap
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    // Randomized pulses
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 4,
          $urandom_range(0, 199) < 3, $urandom_range(0, 99) < 10,
          $urandom_range(0, 399) < 2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
